// File: rtl/serieparalelo_lock_ctrl.sv
// Symbol-lock controller for the serial-to-parallel receive path.
// It enables the deserializer and waits for a run of consecutive COM symbols,
// then forwards data bytes and flags IDL bytes. Lock is kept alive by COMs,
// and is dropped when too many valid bytes pass without one.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   OFF     | link disabled, deserializer off
//   SEARCH  | deserializer on, waiting for the first COM
//   CONFIRM | counting consecutive COMs toward LOCK_CNT
//   LOCKED  | symbol lock held; data forwarded, gap since last COM counted
module serieparalelo_lock_ctrl #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter logic [7:0] IDL      = 8'h7C,
  parameter int         LOCK_CNT = 4,
  parameter int         MAX_GAP  = 16
) (
  input  logic       clk4f,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] data_in,
  input  logic       data_in_vld,
  output logic       sp_en,
  output logic       locked,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       idle,
  output logic       lock_lost,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);
  localparam logic [7:0] MAX_GAP_C  = 8'(MAX_GAP);

  state_t     state_q, state_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       sp_en_q, sp_en_d;
  logic       locked_q, locked_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_out_q, valid_out_d;
  logic       idle_q, idle_d;
  logic       lock_lost_q, lock_lost_d;

  logic       is_com, is_other;
  logic [3:0] com_inc;
  logic [7:0] gap_inc;

  assign is_com   = data_in_vld && (data_in == COM);
  assign is_other = data_in_vld && (data_in != COM);
  assign com_inc  = com_cnt_q + 4'd1;
  assign gap_inc  = gap_cnt_q + 8'd1;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    com_cnt_d   = com_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    idle_d      = 1'b0;
    lock_lost_d = 1'b0;

    // A byte accepted while LOCKED is forwarded even if this edge also drops lock.
    if (state_q == ST_LOCKED && is_other) begin
      if (data_in == IDL) begin
        idle_d = 1'b1;
      end else begin
        valid_out_d = 1'b1;
        data_out_d  = data_in;
      end
    end

    if (!en) begin
      state_d   = ST_OFF;
      com_cnt_d = 4'd0;
      gap_cnt_d = 8'd0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (is_com) begin
            if (LOCK_CNT_C == 4'd1) begin
              state_d   = ST_LOCKED;
              com_cnt_d = 4'd0;
              gap_cnt_d = 8'd0;
            end else begin
              state_d   = ST_CONFIRM;
              com_cnt_d = 4'd1;
            end
          end
        end
        ST_CONFIRM: begin
          if (is_com) begin
            if (com_inc == LOCK_CNT_C) begin
              state_d   = ST_LOCKED;
              com_cnt_d = 4'd0;
              gap_cnt_d = 8'd0;
            end else begin
              com_cnt_d = com_inc;
            end
          end else if (is_other) begin
            state_d   = ST_SEARCH;
            com_cnt_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (is_com) begin
            gap_cnt_d = 8'd0;
          end else if (is_other) begin
            if (gap_inc == MAX_GAP_C) begin
              state_d     = ST_SEARCH;
              lock_lost_d = 1'b1;
              gap_cnt_d   = 8'd0;
              com_cnt_d   = 4'd0;
            end else begin
              gap_cnt_d = gap_inc;
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    sp_en_d  = (state_d != ST_OFF);
    locked_d = (state_d == ST_LOCKED);
  end

  // State, counters and all outputs registered; async active-low clear.
  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_OFF;
      com_cnt_q   <= 4'd0;
      gap_cnt_q   <= 8'd0;
      sp_en_q     <= 1'b0;
      locked_q    <= 1'b0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      idle_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      com_cnt_q   <= com_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sp_en_q     <= sp_en_d;
      locked_q    <= locked_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      idle_q      <= idle_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign sp_en     = sp_en_q;
  assign locked    = locked_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign idle      = idle_q;
  assign lock_lost = lock_lost_q;
  assign state     = state_q;

endmodule

// File: doc/serieparalelo_lock_ctrl.md
Name: serieparalelo_lock_ctrl

Overview:
- Link-lock controller that sequences the serial-to-parallel receive path of the PCIe physical layer.
- Enables the deserializer and hunts for COM (0xBC) symbols in its parallel byte stream.
- Declares symbol lock after LOCK_CNT consecutive COMs, then forwards data bytes with a valid flag and flags IDL (0x7C) bytes.
- Drops lock and re-enters search when no COM arrives within MAX_GAP valid bytes.

Parameters:
COM, 8'hBC, comma symbol used for alignment and lock keep-alive
IDL, 8'h7C, idle symbol, never forwarded as data
LOCK_CNT, 4, consecutive COMs required to enter LOCKED (legal range 1..15)
MAX_GAP, 16, valid bytes allowed since the last COM before lock is lost (legal range 2..255)

Ports:
clk4f  in  1  byte clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
en  in  1  link enable from upper layer
data_in  in  8  parallel byte from deserializer
data_in_vld  in  1  data_in holds a new byte this cycle
sp_en  out  1  enable to the deserializer
locked  out  1  symbol lock achieved
data_out  out  8  forwarded data byte
valid_out  out  1  data_out carries a new data byte this cycle
idle  out  1  the byte accepted last cycle was IDL, while LOCKED
lock_lost  out  1  one-cycle pulse on a lock timeout
state  out  2  current FSM state: 0 OFF, 1 SEARCH, 2 CONFIRM, 3 LOCKED

Behaviour:
- Reset (reset=0, asynchronous):
  - state=OFF; com_cnt=0; gap_cnt=0.
  - All outputs 0, including data_out=8'h00.
- All outputs are registered.
- Bytes with data_in_vld=0 are ignored: no counter changes, valid_out=0, idle=0.
- en=0 in any state forces OFF on the next edge, clears both counters, and raises no lock_lost. This has priority over every other transition.
- OFF:
  - sp_en=0, locked=0.
  - en=1 -> SEARCH.
- SEARCH:
  - sp_en=1.
  - Valid COM -> com_cnt=1. Next state is CONFIRM, or LOCKED if LOCK_CNT=1.
  - Any other valid byte -> stay in SEARCH.
- CONFIRM:
  - Valid COM -> com_cnt+1. When com_cnt+1 equals LOCK_CNT -> LOCKED, with gap_cnt=0 and com_cnt=0.
  - Valid non-COM -> SEARCH, com_cnt=0.
- LOCKED:
  - sp_en=1, locked=1.
  - Valid byte not COM and not IDL: data_out<=byte and valid_out=1 on the next cycle (latency 1), gap_cnt+1.
  - Valid IDL: idle=1 next cycle, valid_out=0, gap_cnt+1.
  - Valid COM: gap_cnt=0, valid_out=0, idle=0.
  - data_out holds its last value whenever valid_out=0.
- Gap timeout: when a valid non-COM byte makes gap_cnt+1 equal MAX_GAP:
  - Next state SEARCH; locked=0 and lock_lost=1 for exactly one cycle.
  - That byte is still forwarded normally (valid_out or idle asserted as usual).
  - gap_cnt=0, com_cnt=0.
- Timeout and en=0 in the same cycle -> OFF, lock_lost=0.
- Counter sizing: com_cnt is 4 bits and gap_cnt is 8 bits. Neither wraps, because each resets at its threshold.
- Reset asserted mid-operation (including while LOCKED) returns all state and outputs to the reset values immediately.
- After reset releases, lock requires a fresh full SEARCH -> CONFIRM sequence.

Test Plan:
1. Reset held, then released with en=0 -> state=0, sp_en=0, locked=0, data_out=00, valid_out=0 on every cycle.
2. en=1, then four valid BC bytes on consecutive cycles -> state goes 1 -> 2 (after 1st BC) -> 3 (after 4th BC), locked=1, lock_lost never set.
3. en=1, stream BC BC 55 BC -> returns to SEARCH on 55 (state=1, com_cnt=0), then state=2 after the final BC; locked stays 0.
4. LOCKED, bytes 11, 7C, 22 with a data_in_vld=0 gap before 22 -> valid_out=1/data_out=11 one cycle later; then idle=1, valid_out=0 with data_out held at 11; then valid_out=1/data_out=22 one cycle after 22 is accepted.
5. LOCKED, 16 valid bytes of A5 with no BC -> the 16th A5 is forwarded, and on the same edge lock_lost pulses 1 for one cycle, locked=0, state=1. Repeat with 15 A5 then BC -> no loss.
6. LOCKED, drive en=0 on the same cycle as the 16th non-COM byte -> state=0, lock_lost=0, sp_en=0. Separately, reset=0 mid-LOCKED -> outputs 0 asynchronously, before the next clk4f edge.
